// File: rtl/b2b_event_stream_checker_pkg.sv
// Shared definitions for the B2B event stream checker: event word field
// layout (mirrors TP_DataFormat), fixed footer CRC marker and checker states.
package b2b_event_stream_checker_pkg;

  // Metadata flag position and the 8-bit word-type flag just below it
  localparam int EVT_META_BIT = 64;
  localparam int EVT_FLAG_W   = 8;

  localparam logic [EVT_FLAG_W-1:0] EVT_HDR_W1_FLAG_FLAG = 8'hAB;
  localparam logic [EVT_FLAG_W-1:0] EVT_FTR_W1_FLAG_FLAG = 8'hCD;

  // Footer word 1 carries the number of metadata words in the event
  localparam int EVT_FTR_W1_META_COUNT_LSB = 0;
  localparam int EVT_FTR_W1_META_COUNT_W   = 16;

  // Footer word 3 carries the event word count and the CRC field
  localparam int EVT_FTR_W3_WORD_COUNT_LSB = 32;
  localparam int EVT_FTR_W3_WORD_COUNT_W   = 32;
  localparam int EVT_FTR_W3_CRC_LSB        = 0;
  localparam int EVT_FTR_W3_CRC_W          = 32;

  // The producer does not compute a CRC yet; it writes this fixed marker
  localparam logic [EVT_FTR_W3_CRC_W-1:0] EVT_FTR_CRC_PLACEHOLDER = 32'hdeadbeef;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BODY,
    ST_FTR2,
    ST_FTR3
  } chk_state_e;

endpackage

// File: rtl/b2b_event_stream_checker_if.sv
// FIFO-read and link-side signals of a B2B event stream stage.
// The slave modport is the checker; the master modport is its environment.
interface b2b_event_stream_checker_if #(
  parameter int DATA_WIDTH = 65
) ();
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] link_data;
  logic                  link_valid;
  logic                  link_ready;

  modport slave (
    input  fifo_rd_data,
    input  fifo_empty,
    output fifo_rd_en,
    output link_data,
    output link_valid,
    input  link_ready
  );

  modport master (
    output fifo_rd_data,
    output fifo_empty,
    input  fifo_rd_en,
    input  link_data,
    input  link_valid,
    output link_ready
  );
endinterface

// File: rtl/b2b_word_classifier.sv
// Combinational word-class decode for B2B event words. Takes only the
// metadata bit and the flag byte below it so any B2B checker can reuse it.
module b2b_word_classifier
  import b2b_event_stream_checker_pkg::*;
(
  input  logic [EVT_FLAG_W:0] word_tag,
  output logic                is_hdr,
  output logic                is_ftr1,
  output logic                is_meta,
  output logic                is_data
);
  logic                  meta_bit;
  logic [EVT_FLAG_W-1:0] flag;

  assign meta_bit = word_tag[EVT_FLAG_W];
  assign flag     = word_tag[EVT_FLAG_W-1:0];

  assign is_hdr  = meta_bit && (flag == EVT_HDR_W1_FLAG_FLAG);
  assign is_ftr1 = meta_bit && (flag == EVT_FTR_W1_FLAG_FLAG);
  assign is_meta = meta_bit && !is_hdr && !is_ftr1;
  assign is_data = !meta_bit;
endmodule

// File: rtl/b2b_event_stream_checker.sv
// Pops merged events from the FWFT output-board FIFO, forwards every word
// unchanged to the board-to-board link and checks event framing in-line.
// Status pulses are registered together with the word they describe.
module b2b_event_stream_checker
  import b2b_event_stream_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 65,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                           b2b_clk,
  input  logic                           b2b_rst,
  b2b_event_stream_checker_if.slave      bus,
  output logic                           evt_done,
  output logic                           err_framing,
  output logic                           err_meta_count,
  output logic                           err_word_count,
  output logic [31:0]                    evt_count,
  output logic [ERR_CNT_W-1:0]           err_count
);

  chk_state_e                           state;
  logic [EVT_FTR_W1_META_COUNT_W-1:0]   meta_cnt;
  logic [EVT_FTR_W3_WORD_COUNT_W-1:0]   word_cnt;

  logic                                 pop;
  logic                                 is_hdr;
  logic                                 is_ftr1;
  logic                                 is_meta;
  logic                                 is_data;
  logic [EVT_FTR_W1_META_COUNT_W-1:0]   ftr_meta_count;
  logic [EVT_FTR_W3_WORD_COUNT_W-1:0]   ftr_word_count;
  logic [EVT_FTR_W3_CRC_W-1:0]          ftr_crc;

  // The error counter sticks at all-ones instead of wrapping
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Pop whenever the link slot is free or being freed this cycle
  assign pop            = !b2b_rst && !bus.fifo_empty && (!bus.link_valid || bus.link_ready);
  assign bus.fifo_rd_en = pop;

  assign ftr_meta_count = bus.fifo_rd_data[EVT_FTR_W1_META_COUNT_LSB +: EVT_FTR_W1_META_COUNT_W];
  assign ftr_word_count = bus.fifo_rd_data[EVT_FTR_W3_WORD_COUNT_LSB +: EVT_FTR_W3_WORD_COUNT_W];
  assign ftr_crc        = bus.fifo_rd_data[EVT_FTR_W3_CRC_LSB +: EVT_FTR_W3_CRC_W];

  b2b_word_classifier u_classifier (
    .word_tag (bus.fifo_rd_data[EVT_META_BIT -: EVT_FLAG_W + 1]),
    .is_hdr   (is_hdr),
    .is_ftr1  (is_ftr1),
    .is_meta  (is_meta),
    .is_data  (is_data)
  );

  // Link register, checker FSM and status counters, advanced once per popped word
  always_ff @(posedge b2b_clk) begin
    if (b2b_rst) begin
      bus.link_data  <= '0;
      bus.link_valid <= 1'b0;
      evt_done       <= 1'b0;
      err_framing    <= 1'b0;
      err_meta_count <= 1'b0;
      err_word_count <= 1'b0;
      evt_count      <= '0;
      err_count      <= '0;
      state          <= ST_IDLE;
      meta_cnt       <= '0;
      word_cnt       <= '0;
    end else begin
      evt_done       <= 1'b0;
      err_framing    <= 1'b0;
      err_meta_count <= 1'b0;
      err_word_count <= 1'b0;
      if (pop) begin
        bus.link_data  <= bus.fifo_rd_data;
        bus.link_valid <= 1'b1;
        case (state)
          ST_IDLE: begin
            if (is_hdr) begin
              state    <= ST_BODY;
              meta_cnt <= 16'd1;
              word_cnt <= 32'd1;
            end else begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
            end
          end
          ST_BODY: begin
            if (is_hdr) begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
              meta_cnt    <= 16'd1;
              word_cnt    <= 32'd1;
            end else if (is_ftr1) begin
              if (ftr_meta_count != meta_cnt) begin
                err_meta_count <= 1'b1;
                err_count      <= sat_inc(err_count);
              end
              state <= ST_FTR2;
            end else if (is_meta) begin
              meta_cnt <= meta_cnt + 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
          ST_FTR2: begin
            if (is_data) begin
              state <= ST_FTR3;
            end else if (is_hdr) begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
              meta_cnt    <= 16'd1;
              word_cnt    <= 32'd1;
              state       <= ST_BODY;
            end else begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
              state       <= ST_IDLE;
            end
          end
          ST_FTR3: begin
            if (is_data) begin
              if ((ftr_word_count != word_cnt) || (ftr_crc != EVT_FTR_CRC_PLACEHOLDER)) begin
                err_word_count <= 1'b1;
                err_count      <= sat_inc(err_count);
              end else begin
                evt_done <= 1'b1;
              end
              evt_count <= evt_count + 1'b1;
              state     <= ST_IDLE;
            end else if (is_hdr) begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
              meta_cnt    <= 16'd1;
              word_cnt    <= 32'd1;
              state       <= ST_BODY;
            end else begin
              err_framing <= 1'b1;
              err_count   <= sat_inc(err_count);
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (bus.link_ready) begin
        bus.link_valid <= 1'b0;
      end
    end
  end

endmodule
